sd_cmd_engine: RTL and testbench

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

---
 rtl/sd_pkg.sv | 40 ++++
 rtl/sd_crc7.sv | 23 ++
 rtl/sd_cmd_engine.sv | 187 ++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared state encoding, SD command framing constants and the byte-serial CRC7 step
// used by the SD command engine.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BUILD,
    ST_SEND,
    ST_WAIT_TX,
    ST_POLL,
    ST_WAIT_POLL,
    ST_READ,
    ST_WAIT_RD,
    ST_DONE
  } sd_state_e;

  localparam logic [2:0] RESP_LEN_R1  = 3'd1;
  localparam logic [2:0] RESP_LEN_R7  = 3'd5;
  localparam logic [1:0] CMD_START_TX = 2'b01;  // start bit 0 followed by transmission bit 1
  localparam logic       CMD_END_BIT  = 1'b1;
  localparam logic [6:0] CRC7_POLY    = 7'h09;  // x^7 + x^3 + 1 with the x^7 term implied

  // Advance a CRC7 remainder over one byte, MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    return c;
  endfunction

  // Lengths outside 1..5 fall back to a single R1 byte.
  function automatic logic [2:0] norm_resp_len(input logic [2:0] len);
    return (len == 3'd0 || len > RESP_LEN_R7) ? RESP_LEN_R1 : len;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 accumulator with synchronous clear and update enable.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'd0;
    end else if (clr) begin
      crc <= 7'd0;
    end else if (en) begin
      crc <= crc7_byte(crc, data);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD command engine: frames a 6-byte command into a shared buffer, sends it through the
// SPI controller, polls for the R1 start byte and collects the rest of the response.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int BUF_BYTES = 8,
  parameter int NCR_MAX   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [5:0]                   cmd_index,
  input  logic [31:0]                  cmd_arg,
  input  logic [2:0]                   resp_len,
  output logic                         resp_valid,
  output logic [39:0]                  resp_data,
  output logic                         resp_timeout,
  output logic                         busy,
  output logic                         spi_start,
  output logic                         spi_op,
  output logic [$clog2(BUF_BYTES)-1:0] spi_size,
  input  logic                         spi_done,
  input  logic [$clog2(BUF_BYTES)-1:0] spi_address,
  output logic [7:0]                   spi_data_in,
  input  logic [7:0]                   spi_data_out,
  input  logic                         spi_wr
);

  localparam int AW = $clog2(BUF_BYTES);
  localparam int PW = $clog2(NCR_MAX + 1);

  sd_state_e         state_q, state_d;
  logic [2:0]        bidx_q;
  logic [PW-1:0]     poll_q;
  logic [5:0]        idx_q;
  logic [31:0]       arg_q;
  logic [2:0]        len_q;
  logic [7:0]        buf_q    [BUF_BYTES];
  logic [7:0]        buf_view [BUF_BYTES];
  logic [7:0]        build_byte;
  logic [7:0]        poll_byte;
  logic [6:0]        crc;
  logic [AW-1:0]     rd_size;
  logic              accept;
  logic              wr_en;
  logic              poll_last;

  assign accept    = (state_q == ST_IDLE) && cmd_valid;
  assign wr_en     = spi_wr && (state_q != ST_BUILD);
  assign poll_byte = buf_view[0];
  assign poll_last = (poll_q == PW'(NCR_MAX - 1));
  assign rd_size   = AW'(len_q - 3'd2);

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign resp_valid  = (state_q == ST_DONE);
  assign spi_data_in = buf_q[spi_address];

  always_comb begin
    build_byte = {crc, CMD_END_BIT};
    case (bidx_q)
      3'd0:    build_byte = {CMD_START_TX, idx_q};
      3'd1:    build_byte = arg_q[31:24];
      3'd2:    build_byte = arg_q[23:16];
      3'd3:    build_byte = arg_q[15:8];
      3'd4:    build_byte = arg_q[7:0];
      default: build_byte = {crc, CMD_END_BIT};
    endcase
  end

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    ((state_q == ST_BUILD) && (bidx_q != 3'd5)),
    .data  (build_byte),
    .crc   (crc)
  );

  // A byte landing on the same edge as spi_done is forwarded so it is not missed.
  always_comb begin
    for (int i = 0; i < BUF_BYTES; i++) begin
      buf_view[i] = buf_q[i];
      if (wr_en && spi_address == AW'(i)) buf_view[i] = spi_data_out;
    end
  end

  always_comb begin
    state_d   = state_q;
    spi_start = 1'b0;
    spi_op    = 1'b0;
    spi_size  = '0;
    case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = ST_BUILD;
      ST_BUILD:   if (bidx_q == 3'd5) state_d = ST_SEND;
      ST_SEND: begin
        spi_start = 1'b1;
        spi_op    = 1'b1;
        spi_size  = AW'(5);
        state_d   = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        spi_op   = 1'b1;
        spi_size = AW'(5);
        if (spi_done) state_d = ST_POLL;
      end
      ST_POLL: begin
        spi_start = 1'b1;
        state_d   = ST_WAIT_POLL;
      end
      ST_WAIT_POLL: begin
        if (spi_done) begin
          if (poll_byte[7]) state_d = poll_last ? ST_DONE : ST_POLL;
          else              state_d = (len_q == RESP_LEN_R1) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        spi_start = 1'b1;
        spi_size  = rd_size;
        state_d   = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        spi_size = rd_size;
        if (spi_done) state_d = ST_DONE;
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bidx_q       <= 3'd0;
      poll_q       <= '0;
      resp_data    <= 40'd0;
      resp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            bidx_q       <= 3'd0;
            poll_q       <= '0;
            resp_data    <= 40'd0;
            resp_timeout <= 1'b0;
          end
        end
        ST_BUILD: bidx_q <= bidx_q + 3'd1;
        ST_WAIT_POLL: begin
          if (spi_done) begin
            if (poll_byte[7]) begin
              poll_q <= poll_q + PW'(1);
              if (poll_last) begin
                resp_timeout <= 1'b1;
                resp_data    <= 40'hFF00000000;
              end
            end else begin
              resp_data[39:32] <= poll_byte;
            end
          end
        end
        ST_WAIT_RD: begin
          if (spi_done) begin
            for (int i = 0; i < 4; i++) begin
              if (3'(i) < len_q - 3'd1) resp_data[31-8*i -: 8] <= buf_view[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data path: command fields and the transfer buffer carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= cmd_index;
      arg_q <= cmd_arg;
      len_q <= norm_resp_len(resp_len);
    end
    if (state_q == ST_BUILD) buf_q[AW'(bidx_q)] <= build_byte;
    else if (spi_wr)         buf_q[spi_address] <= spi_data_out;
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: an in-bench SPI slave serves transfers while
// fixed vectors, directed corner sequences and random commands are checked.
module tb_sd_cmd_engine;

  localparam int BUF_BYTES = 8;
  localparam int NCR       = 8;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [2:0]  len;
    int          nff;
    int          nrsp;
    logic [39:0] rsp;
    logic [47:0] frame;
    logic [39:0] data;
    logic        tout;
    int          reads;
    int          rbytes;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [2:0]  resp_len = '0;
  logic        resp_valid;
  logic [39:0] resp_data;
  logic        resp_timeout;
  logic        busy;
  logic        spi_start;
  logic        spi_op;
  logic [2:0]  spi_size;
  logic        spi_done = 1'b0;
  logic [2:0]  spi_address = '0;
  logic [7:0]  spi_data_in;
  logic [7:0]  spi_data_out = '0;
  logic        spi_wr = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  rsp_q [$];
  logic        g_got, g_tout, g_inject = 1'b0;
  logic [39:0] g_data;
  logic [47:0] g_frame;
  int          g_reads, g_rbytes, g_writes, g_hold_err, g_ready_err;

  sd_cmd_engine #(.BUF_BYTES(BUF_BYTES), .NCR_MAX(NCR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .resp_len     (resp_len),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .spi_start    (spi_start),
    .spi_op       (spi_op),
    .spi_size     (spi_size),
    .spi_done     (spi_done),
    .spi_address  (spi_address),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_wr       (spi_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference CRC7 by long division of the 40-bit message times x^7.
  function automatic logic [6:0] ref_crc(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // Walk the slave's byte stream as the card protocol describes it.
  function automatic void ref_resp(input byte_q_t q, input logic [2:0] len,
                                   output logic [39:0] d, output logic t,
                                   output int reads, output int rbytes);
    int eff, p;
    logic [7:0] b;
    eff = (len == 3'd0 || len > 3'd5) ? 1 : int'(len);
    d = '0; t = 1'b1; p = 0; reads = 0; rbytes = 0;
    for (int k = 0; k < NCR && t; k++) begin
      b = (p < q.size()) ? q[p] : 8'hFF;
      p++; reads++; rbytes++;
      if (!b[7]) begin
        t = 1'b0;
        d[39:32] = b;
        for (int j = 1; j < eff; j++) begin
          d[39-8*j -: 8] = (p < q.size()) ? q[p] : 8'hFF;
          p++;
        end
        if (eff > 1) begin reads++; rbytes += eff - 1; end
      end
    end
    if (t) d = 40'hFF00000000;
  endfunction

  task automatic xfer();
    logic       op;
    logic [2:0] sz;
    op = spi_op;
    sz = spi_size;
    if (op) g_writes++;
    else begin g_reads++; g_rbytes += int'(sz) + 1; end
    @(negedge clk);
    if (spi_start !== 1'b0) g_hold_err++;
    for (int b = 0; b <= int'(sz); b++) begin
      spi_address = 3'(b);
      if (op) begin
        #1;
        if (b < 6) g_frame[47-8*b -: 8] = spi_data_in;
      end else begin
        spi_wr = 1'b1;
        spi_data_out = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hFF;
      end
      if (spi_op !== op || spi_size !== sz) g_hold_err++;
      @(negedge clk);
    end
    spi_wr = 1'b0;
    spi_done = 1'b1;
    if (spi_op !== op || spi_size !== sz) g_hold_err++;
    @(negedge clk);
    spi_done = 1'b0;
  endtask

  // Serve SPI transfers until resp_valid, within a bounded number of cycles.
  task automatic service();
    g_got = 1'b0; g_frame = '0; g_reads = 0; g_rbytes = 0; g_writes = 0;
    g_hold_err = 0; g_ready_err = 0;
    for (int c = 0; c < 400 && !g_got; c++) begin
      if (g_inject) begin
        if (c < 6) begin
          spi_wr = 1'b1; spi_address = 3'(c); spi_data_out = 8'hEE; spi_done = 1'b1;
        end else if (c == 6) begin
          spi_wr = 1'b0; spi_done = 1'b0;
        end
      end
      if (resp_valid) begin
        g_got = 1'b1; g_data = resp_data; g_tout = resp_timeout;
      end else begin
        if (cmd_ready !== 1'b0 || busy !== 1'b1) g_ready_err++;
        if (spi_start) xfer();
        else @(negedge clk);
      end
    end
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] len,
                       input bit hold);
    cmd_index = idx; cmd_arg = arg; resp_len = len; cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [2:0] len);
    issue(idx, arg, len, 1'b0);
    service();
    if (g_got) begin
      @(negedge clk);
      chk({tag, "_pulse"}, 64'({resp_valid, cmd_ready}), 64'(2'b01));
    end
  endtask

  task automatic check_cmd(input string tag, input logic [47:0] frame, input logic [39:0] data,
                           input logic tout, input int reads, input int rbytes);
    chk({tag, "_valid"},  64'(g_got),       64'(1'b1));
    chk({tag, "_frame"},  64'(g_frame),     64'(frame));
    chk({tag, "_data"},   64'(g_data),      64'(data));
    chk({tag, "_tout"},   64'(g_tout),      64'(tout));
    chk({tag, "_reads"},  64'(g_reads),     64'(reads));
    chk({tag, "_rbytes"}, 64'(g_rbytes),    64'(rbytes));
    chk({tag, "_writes"}, 64'(g_writes),    64'(1));
    chk({tag, "_hold"},   64'(g_hold_err),  64'(0));
    chk({tag, "_ready"},  64'(g_ready_err), 64'(0));
  endtask

  vec_t vt [10];

  initial begin
    logic [39:0] ed;
    logic        et, found;
    int          er, eb, seen;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic [2:0]  rlen;
    byte_q_t     rq;

    vt[0] = '{6'd0,  32'h0,        3'd1, 1, 1, 40'h0100000000, 48'h400000000095, 40'h0100000000, 1'b0, 2, 2};
    vt[1] = '{6'd8,  32'h000001AA, 3'd5, 2, 5, 40'h01000001AA, 48'h48000001AA87, 40'h01000001AA, 1'b0, 4, 7};
    vt[2] = '{6'd55, 32'h0,        3'd1, 0, 0, 40'h0,          48'h770000000065, 40'hFF00000000, 1'b1, 8, 8};
    vt[3] = '{6'd41, 32'h40000000, 3'd1, 0, 1, 40'h0,          48'h694000000077, 40'h0000000000, 1'b0, 1, 1};
    vt[4] = '{6'd58, 32'h0,        3'd5, 1, 5, 40'h00C0FF8000, 48'h7A00000000FD, 40'h00C0FF8000, 1'b0, 3, 6};
    vt[5] = '{6'd0,  32'h0,        3'd0, 0, 1, 40'h0100000000, 48'h400000000095, 40'h0100000000, 1'b0, 1, 1};
    vt[6] = '{6'd0,  32'h0,        3'd7, 0, 5, 40'h01AABBCCDD, 48'h400000000095, 40'h0100000000, 1'b0, 1, 1};
    vt[7] = '{6'd8,  32'h000001AA, 3'd3, 0, 3, 40'h01ABCD0000, 48'h48000001AA87, 40'h01ABCD0000, 1'b0, 2, 3};
    vt[8] = '{6'd0,  32'h0,        3'd1, 7, 1, 40'h0500000000, 48'h400000000095, 40'h0500000000, 1'b0, 8, 8};
    vt[9] = '{6'd55, 32'h0,        3'd5, 8, 5, 40'h0000000000, 48'h770000000065, 40'hFF00000000, 1'b1, 8, 8};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({cmd_ready, busy, spi_start, spi_op, spi_size, resp_valid, resp_timeout}),
        64'(9'b1_0000_0000));
    chk("reset_data", 64'(resp_data), 64'(40'd0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      rsp_q.delete();
      repeat (vt[i].nff) rsp_q.push_back(8'hFF);
      for (int j = 0; j < vt[i].nrsp; j++) rsp_q.push_back(vt[i].rsp[39-8*j -: 8]);
      run_cmd($sformatf("vec%0d", i), vt[i].idx, vt[i].arg, vt[i].len);
      check_cmd($sformatf("vec%0d", i), vt[i].frame, vt[i].data, vt[i].tout, vt[i].reads, vt[i].rbytes);
    end

    // Stray spi_done in IDLE must not start or finish anything.
    seen = 0;
    spi_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) seen++;
    end
    spi_done = 1'b0;
    chk("idle_done_ignored", 64'(seen), 64'(0));

    // spi_wr and spi_done during BUILD must not disturb the frame.
    rsp_q.delete();
    rsp_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    g_inject = 1'b1;
    run_cmd("inject", 6'd8, 32'h000001AA, 3'd5);
    g_inject = 1'b0;
    check_cmd("inject", 48'h48000001AA87, 40'h01000001AA, 1'b0, 2, 5);

    // cmd_valid held through a whole command: re-accept only after resp_valid.
    rsp_q.delete();
    rsp_q = '{8'hFF, 8'h01, 8'h01};
    issue(6'd0, 32'h0, 3'd1, 1'b1);
    service();
    check_cmd("hold1", 48'h400000000095, 40'h0100000000, 1'b0, 2, 2);
    @(negedge clk);
    chk("hold_idle", 64'({cmd_ready, busy}), 64'(2'b10));
    @(negedge clk);
    chk("hold_reaccept", 64'({cmd_ready, busy}), 64'(2'b01));
    cmd_valid = 1'b0;
    service();
    check_cmd("hold2", 48'h400000000095, 40'h0100000000, 1'b0, 1, 1);
    @(negedge clk);

    // Reset while waiting for the command transmit to finish.
    rsp_q.delete();
    issue(6'd0, 32'h0, 3'd1, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (spi_start) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach_send", 64'(found), 64'(1'b1));
    @(negedge clk);
    chk("rst_in_wait_tx", 64'({busy, spi_op, spi_start}), 64'(3'b110));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({cmd_ready, busy, spi_start, spi_op, spi_size, resp_valid, resp_timeout}),
        64'(9'b1_0000_0000));
    chk("rst_mid_data", 64'(resp_data), 64'(40'd0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) seen++;
    end
    chk("rst_no_resp", 64'(seen), 64'(0));
    rsp_q = '{8'h01};
    run_cmd("after_rst", 6'd0, 32'h0, 3'd1);
    check_cmd("after_rst", 48'h400000000095, 40'h0100000000, 1'b0, 1, 1);

    // Random commands against the behavioural model.
    for (int n = 0; n < 30; n++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom();
      rlen = 3'($urandom_range(0, 7));
      rq.delete();
      repeat ($urandom_range(0, 10)) rq.push_back(8'(8'h80 | $urandom_range(0, 127)));
      rq.push_back(8'($urandom_range(0, 127)));
      repeat (4) rq.push_back(8'($urandom_range(0, 255)));
      rsp_q = rq;
      ref_resp(rq, rlen, ed, et, er, eb);
      run_cmd($sformatf("rnd%0d", n), ridx, rarg, rlen);
      check_cmd($sformatf("rnd%0d", n),
                {2'b01, ridx, rarg, ref_crc({2'b01, ridx, rarg}), 1'b1}, ed, et, er, eb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
